// File: rtl/cam_mock_pkg.sv
// Shared types, framing constants and pixel pattern for the OV7670 RGB565 port emulator.
package cam_mock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        LINE,
        HBLANK,
        VFRONT,
        DONE
    } state_t;

    localparam int unsigned VSYNC_PCLKS  = 4;
    localparam int unsigned VBACK_PCLKS  = 8;
    localparam int unsigned HBLANK_PCLKS = 8;
    localparam int unsigned VFRONT_PCLKS = 8;

    // Checkable pattern: frame, row and column packed into one RGB565 word.
    function automatic logic [15:0] pix_word(input logic [3:0] f,
                                             input logic [5:0] r,
                                             input logic [5:0] c);
        return {f, r, c};
    endfunction

endpackage

// File: rtl/cam_mock_pclk_gen.sv
// Divide-by-2 pixel clock register plus a strobe marking the xclk edge where pclk falls.
module cam_mock_pclk_gen (
    input  logic i_xclk,
    input  logic i_reset,
    output logic o_pclk,
    output logic o_fall
);

    logic r_pclk;

    always_ff @(posedge i_xclk) begin
        if (i_reset) begin
            r_pclk <= 1'b0;
        end else begin
            r_pclk <= ~r_pclk;
        end
    end

    // pclk is high now, so the coming edge takes it low.
    assign o_pclk = r_pclk;
    assign o_fall = r_pclk;

endmodule

// File: rtl/cam_data_mock.sv
// OV7670-style parallel camera source: pclk, VSYNC/HREF framing and a two-byte-per-pixel
// test pattern for a fixed number of frames, then a sticky done flag.
module cam_data_mock
    import cam_mock_pkg::*;
#(
    parameter int PCLK_FREQ_MHZ  = 24,
    parameter int FRAME_WIDTH    = 640,
    parameter int FRAME_HEIGHT   = 480,
    parameter int FRAMES_TO_SEND = 10
) (
    input  logic       xclk,
    input  logic       reset,
    input  logic       enable,
    output logic       pclk,
    output logic       vsync,
    output logic       href,
    output logic [7:0] data_out,
    output logic       frame_done,
    output logic [1:0] current_frame
);

    localparam int unsigned COL_W = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam int unsigned ROW_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int unsigned FRM_W = ($clog2(FRAMES_TO_SEND + 1) > 2) ? $clog2(FRAMES_TO_SEND + 1) : 2;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(FRAME_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_HEIGHT - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAMES_TO_SEND);

    localparam logic [2:0] VSYNC_END  = 3'(VSYNC_PCLKS - 1);
    localparam logic [2:0] VBACK_END  = 3'(VBACK_PCLKS - 1);
    localparam logic [2:0] HBLANK_END = 3'(HBLANK_PCLKS - 1);
    localparam logic [2:0] VFRONT_END = 3'(VFRONT_PCLKS - 1);

    generate
        if (FRAMES_TO_SEND < 1 || PCLK_FREQ_MHZ < 1) begin : g_bad_params
            $error("cam_data_mock: FRAMES_TO_SEND and PCLK_FREQ_MHZ must be >= 1");
        end
    endgenerate

    logic             w_fall;
    state_t           r_state;
    logic [2:0]       r_cnt;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             r_lo;
    logic [FRM_W-1:0] r_frames;
    logic             r_vsync;
    logic             r_href;
    logic [7:0]       r_data;
    logic             r_done;

    logic [ROW_W-1:0] w_sel_row;
    logic [COL_W-1:0] w_sel_col;
    logic [15:0]      w_pix;
    logic [FRM_W-1:0] w_frames_nxt;

    cam_mock_pclk_gen u_pclk_gen (
        .i_xclk  (xclk),
        .i_reset (reset),
        .o_pclk  (pclk),
        .o_fall  (w_fall)
    );

    // One pattern lookup serves every byte: the low byte of the current pixel, or the
    // high byte of whichever pixel the state machine is about to start.
    always_comb begin
        w_sel_row = r_row;
        w_sel_col = r_col;
        case (r_state)
            VBACK: begin
                w_sel_row = '0;
                w_sel_col = '0;
            end
            LINE: begin
                if (r_lo) begin
                    w_sel_col = r_col + 1'b1;
                end
            end
            HBLANK: begin
                w_sel_row = r_row + 1'b1;
                w_sel_col = '0;
            end
            default: ;
        endcase
        w_pix        = pix_word(4'(r_frames), 6'(w_sel_row), 6'(w_sel_col));
        w_frames_nxt = r_frames + 1'b1;
    end

    always_ff @(posedge xclk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_lo     <= 1'b0;
            r_frames <= '0;
            r_vsync  <= 1'b0;
            r_href   <= 1'b0;
            r_data   <= '0;
            r_done   <= 1'b0;
        end else if (w_fall) begin
            case (r_state)
                IDLE: begin
                    if (enable && !r_done) begin
                        r_state <= VSYNC;
                        r_vsync <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                VSYNC: begin
                    if (r_cnt == VSYNC_END) begin
                        r_state <= VBACK;
                        r_vsync <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                VBACK: begin
                    if (r_cnt == VBACK_END) begin
                        r_state <= LINE;
                        r_href  <= 1'b1;
                        r_data  <= w_pix[15:8];
                        r_row   <= '0;
                        r_col   <= '0;
                        r_lo    <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                LINE: begin
                    if (!r_lo) begin
                        r_data <= w_pix[7:0];
                        r_lo   <= 1'b1;
                    end else if (r_col == COL_LAST) begin
                        r_href  <= 1'b0;
                        r_data  <= '0;
                        r_lo    <= 1'b0;
                        r_col   <= '0;
                        r_state <= (r_row == ROW_LAST) ? VFRONT : HBLANK;
                    end else begin
                        r_col  <= w_sel_col;
                        r_data <= w_pix[15:8];
                        r_lo   <= 1'b0;
                    end
                end
                HBLANK: begin
                    if (r_cnt == HBLANK_END) begin
                        r_state <= LINE;
                        r_href  <= 1'b1;
                        r_data  <= w_pix[15:8];
                        r_row   <= w_sel_row;
                        r_col   <= '0;
                        r_lo    <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                VFRONT: begin
                    if (r_cnt == VFRONT_END) begin
                        r_frames <= w_frames_nxt;
                        r_cnt    <= '0;
                        if (w_frames_nxt == FRM_LAST) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else if (enable) begin
                            r_state <= VSYNC;
                            r_vsync <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: ;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign vsync         = r_vsync;
    assign href          = r_href;
    assign data_out      = r_data;
    assign frame_done    = r_done;
    assign current_frame = r_frames[1:0];

endmodule

// File: tb/tb_cam_data_mock.sv
// Directed bench for cam_data_mock with an 8x4 frame and 10 frames to send.
module tb_cam_data_mock;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int NF = 10;

    logic       xclk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] data_out;
    logic       frame_done;
    logic [1:0] current_frame;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 xclk = ~xclk;

    cam_data_mock #(
        .PCLK_FREQ_MHZ  (24),
        .FRAME_WIDTH    (W),
        .FRAME_HEIGHT   (H),
        .FRAMES_TO_SEND (NF)
    ) dut (
        .xclk          (xclk),
        .reset         (reset),
        .enable        (enable),
        .pclk          (pclk),
        .vsync         (vsync),
        .href          (href),
        .data_out      (data_out),
        .frame_done    (frame_done),
        .current_frame (current_frame)
    );

    // Consumer-side monitor: samples on xclk falling edges, bytes taken while pclk is high.
    bit         mon_clr = 1'b1;
    int         cyc = 0;
    int         vs_rises, href_pulses, line_idx, byte_idx, hlen, hgap, bad_data;
    int         vs_time [16];
    int         frame_hrefs [16];
    int         hlen_q [$];
    int         gap_q [$];
    logic [7:0] mem [0:15][0:3][0:15];
    logic       prev_vs = 1'b0;
    logic       prev_href = 1'b0;

    always @(negedge xclk) begin
        int f;
        cyc++;
        if (mon_clr) begin
            vs_rises = 0; href_pulses = 0; line_idx = -1; byte_idx = 0;
            hlen = 0; hgap = 0; bad_data = 0;
            hlen_q.delete();
            gap_q.delete();
            for (int i = 0; i < 16; i++) begin
                vs_time[i] = 0;
                frame_hrefs[i] = 0;
                for (int j = 0; j < 4; j++)
                    for (int k = 0; k < 16; k++)
                        mem[i][j][k] = 8'hEE;
            end
        end else begin
            if (vsync && !prev_vs) begin
                if (vs_rises < 16) vs_time[vs_rises] = cyc;
                vs_rises++;
                line_idx = -1;
            end
            if (href && !prev_href) begin
                href_pulses++;
                if (line_idx >= 0) gap_q.push_back(hgap);
                line_idx++;
                byte_idx = 0;
                hlen = 0;
                if (vs_rises >= 1 && vs_rises <= 16) frame_hrefs[vs_rises-1]++;
            end
            if (!href && prev_href) begin
                hlen_q.push_back(hlen);
                hgap = 0;
            end
            if (!href && data_out !== 8'h00) bad_data++;
            if (pclk) begin
                if (href) begin
                    f = vs_rises - 1;
                    if (f >= 0 && f < 16 && line_idx >= 0 && line_idx < 4 && byte_idx < 16)
                        mem[f][line_idx][byte_idx] = data_out;
                    byte_idx++;
                    hlen++;
                end else begin
                    hgap++;
                end
            end
        end
        prev_vs   = vsync;
        prev_href = href;
    end

    task automatic test_reset();
        mon_clr = 1'b1;
        reset   = 1'b1;
        enable  = 1'b0;
        repeat (5) @(negedge xclk);
        n_checks++; if (pclk !== 1'b0) begin n_fail++; $display("FAIL reset_pclk got=%b exp=0", pclk); end
        n_checks++; if (vsync !== 1'b0) begin n_fail++; $display("FAIL reset_vsync got=%b exp=0", vsync); end
        n_checks++; if (href !== 1'b0) begin n_fail++; $display("FAIL reset_href got=%b exp=0", href); end
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", data_out); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", frame_done); end
        n_checks++; if (current_frame !== 2'd0) begin n_fail++; $display("FAIL reset_cf got=%0d exp=0", current_frame); end
        enable = 1'b1;
        repeat (3) @(negedge xclk);
        n_checks++; if (vsync !== 1'b0) begin n_fail++; $display("FAIL reset_hold_vsync got=%b exp=0", vsync); end
    endtask

    task automatic test_startup();
        int n, k, g;
        mon_clr = 1'b0;
        reset   = 1'b0;
        n = 0;
        while (!vsync && n < 10) begin @(negedge xclk); n++; end
        n_checks++;
        if (!(vsync === 1'b1 && n >= 1 && n <= 2)) begin
            n_fail++; $display("FAIL start_latency got=%0d xclk exp=1..2", n);
        end
        k = 0;
        while (vsync && k < 40) begin @(negedge xclk); k++; end
        n_checks++; if (k != 8) begin n_fail++; $display("FAIL vsync_width got=%0d xclk exp=8", k); end
        g = 0;
        while (!href && g < 100) begin @(negedge xclk); g++; end
        n_checks++; if (g != 16) begin n_fail++; $display("FAIL vback_width got=%0d xclk exp=16", g); end
    endtask

    task automatic test_pattern();
        int n;
        n = 0;
        while (vs_rises < 3 && n < 600) begin @(negedge xclk); n++; end
        n_checks++; if (vs_rises < 3) begin n_fail++; $display("FAIL pat_wait got=%0d frames exp=3", vs_rises); end
        n_checks++; if (mem[0][1][4] !== 8'h00) begin n_fail++; $display("FAIL pat_f0r1c2_hi got=%h exp=00", mem[0][1][4]); end
        n_checks++; if (mem[0][1][5] !== 8'h42) begin n_fail++; $display("FAIL pat_f0r1c2_lo got=%h exp=42", mem[0][1][5]); end
        n_checks++; if (mem[0][3][15] !== 8'hC7) begin n_fail++; $display("FAIL pat_f0r3c7_lo got=%h exp=c7", mem[0][3][15]); end
        n_checks++; if (mem[1][3][14] !== 8'h10) begin n_fail++; $display("FAIL pat_f1r3c7_hi got=%h exp=10", mem[1][3][14]); end
        n_checks++; if (mem[1][3][15] !== 8'hC7) begin n_fail++; $display("FAIL pat_f1r3c7_lo got=%h exp=c7", mem[1][3][15]); end
    endtask

    task automatic test_line_timing();
        n_checks++; if (frame_hrefs[0] != 4) begin n_fail++; $display("FAIL hrefs_f0 got=%0d exp=4", frame_hrefs[0]); end
        n_checks++; if (frame_hrefs[1] != 4) begin n_fail++; $display("FAIL hrefs_f1 got=%0d exp=4", frame_hrefs[1]); end
        n_checks++; if (hlen_q.size() < 8) begin n_fail++; $display("FAIL hlen_count got=%0d exp>=8", hlen_q.size()); end
        for (int i = 0; i < 8 && i < hlen_q.size(); i++) begin
            n_checks++;
            if (hlen_q[i] != 16) begin n_fail++; $display("FAIL href_len[%0d] got=%0d exp=16", i, hlen_q[i]); end
        end
        n_checks++; if (gap_q.size() < 6) begin n_fail++; $display("FAIL gap_count got=%0d exp>=6", gap_q.size()); end
        for (int i = 0; i < 6 && i < gap_q.size(); i++) begin
            n_checks++;
            if (gap_q[i] != 8) begin n_fail++; $display("FAIL hblank_len[%0d] got=%0d exp=8", i, gap_q[i]); end
        end
        n_checks++; if (vs_time[1] - vs_time[0] != 216) begin n_fail++; $display("FAIL frame_len0 got=%0d exp=216", vs_time[1] - vs_time[0]); end
        n_checks++; if (vs_time[2] - vs_time[1] != 216) begin n_fail++; $display("FAIL frame_len1 got=%0d exp=216", vs_time[2] - vs_time[1]); end
    endtask

    task automatic test_enable_drop();
        int n;
        repeat (60) @(negedge xclk);
        enable = 1'b0;
        n = 0;
        while (current_frame !== 2'd3 && n < 400) begin @(negedge xclk); n++; end
        n_checks++; if (current_frame !== 2'd3) begin n_fail++; $display("FAIL drop_cf got=%0d exp=3", current_frame); end
        repeat (400) @(negedge xclk);
        n_checks++; if (vs_rises != 3) begin n_fail++; $display("FAIL drop_idle_vs got=%0d exp=3", vs_rises); end
        n_checks++; if (frame_hrefs[2] != 4) begin n_fail++; $display("FAIL drop_hrefs_f2 got=%0d exp=4", frame_hrefs[2]); end
        n_checks++; if (href !== 1'b0) begin n_fail++; $display("FAIL drop_idle_href got=%b exp=0", href); end
        enable = 1'b1;
        n = 0;
        while (vs_rises < 4 && n < 10) begin @(negedge xclk); n++; end
        n_checks++; if (vs_rises != 4) begin n_fail++; $display("FAIL resume_vs got=%0d exp=4", vs_rises); end
        n = 0;
        while (current_frame !== 2'd0 && n < 400) begin @(negedge xclk); n++; end
        n_checks++; if (mem[3][0][0] !== 8'h30) begin n_fail++; $display("FAIL pat_f3r0c0_hi got=%h exp=30", mem[3][0][0]); end
        n_checks++; if (mem[3][0][1] !== 8'h00) begin n_fail++; $display("FAIL pat_f3r0c0_lo got=%h exp=00", mem[3][0][1]); end
        n_checks++; if (mem[3][2][3] !== 8'h81) begin n_fail++; $display("FAIL pat_f3r2c1_lo got=%h exp=81", mem[3][2][3]); end
        n_checks++; if (frame_hrefs[3] != 4) begin n_fail++; $display("FAIL hrefs_f3 got=%0d exp=4", frame_hrefs[3]); end
    endtask

    task automatic test_done();
        int n, hp;
        n = 0;
        while (frame_done !== 1'b1 && n < 3000) begin @(negedge xclk); n++; end
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL done_rise got=%b exp=1", frame_done); end
        n_checks++; if (current_frame !== 2'd2) begin n_fail++; $display("FAIL done_cf got=%0d exp=2", current_frame); end
        n_checks++; if (vs_rises != NF) begin n_fail++; $display("FAIL done_vs_count got=%0d exp=%0d", vs_rises, NF); end
        hp = href_pulses;
        repeat (500) @(negedge xclk);
        n_checks++; if (vs_rises != NF) begin n_fail++; $display("FAIL done_quiet_vs got=%0d exp=%0d", vs_rises, NF); end
        n_checks++; if (href_pulses != hp) begin n_fail++; $display("FAIL done_quiet_href got=%0d exp=%0d", href_pulses, hp); end
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL done_sticky got=%b exp=1", frame_done); end
        n_checks++; if (bad_data != 0) begin n_fail++; $display("FAIL data_when_idle got=%0d exp=0", bad_data); end
    endtask

    task automatic test_reset_recovery();
        int n;
        reset = 1'b1;
        @(negedge xclk);
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_done_flag got=%b exp=0", frame_done); end
        n_checks++; if (current_frame !== 2'd0) begin n_fail++; $display("FAIL rst_done_cf got=%0d exp=0", current_frame); end
        n_checks++; if (pclk !== 1'b0) begin n_fail++; $display("FAIL rst_done_pclk got=%b exp=0", pclk); end
        mon_clr = 1'b1;
        @(negedge xclk);
        mon_clr = 1'b0;
        @(negedge xclk);
        reset = 1'b0;
        n = 0;
        while (!(href === 1'b1 && line_idx == 1 && byte_idx >= 6) && n < 400) begin @(negedge xclk); n++; end
        n_checks++; if (href !== 1'b1) begin n_fail++; $display("FAIL midline_reach got=%b exp=1", href); end
        n_checks++; if (mem[0][1][4] !== 8'h00) begin n_fail++; $display("FAIL restart_f0r1c2_hi got=%h exp=00", mem[0][1][4]); end
        n_checks++; if (mem[0][1][5] !== 8'h42) begin n_fail++; $display("FAIL restart_f0r1c2_lo got=%h exp=42", mem[0][1][5]); end
        reset = 1'b1;
        @(negedge xclk);
        n_checks++; if (href !== 1'b0) begin n_fail++; $display("FAIL rst_mid_href got=%b exp=0", href); end
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data got=%h exp=00", data_out); end
        n_checks++; if (pclk !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pclk got=%b exp=0", pclk); end
        mon_clr = 1'b1;
        @(negedge xclk);
        mon_clr = 1'b0;
        @(negedge xclk);
        reset = 1'b0;
        n = 0;
        while (!(line_idx >= 0 && byte_idx >= 2) && n < 200) begin @(negedge xclk); n++; end
        n_checks++; if (vs_rises != 1) begin n_fail++; $display("FAIL restart_vs got=%0d exp=1", vs_rises); end
        n_checks++; if (mem[0][0][0] !== 8'h00) begin n_fail++; $display("FAIL restart_f0r0c0_hi got=%h exp=00", mem[0][0][0]); end
        n_checks++; if (mem[0][0][1] !== 8'h00) begin n_fail++; $display("FAIL restart_f0r0c0_lo got=%h exp=00", mem[0][0][1]); end
        n_checks++; if (current_frame !== 2'd0) begin n_fail++; $display("FAIL restart_cf got=%0d exp=0", current_frame); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_pattern();
        test_line_timing();
        test_enable_drop();
        test_done();
        test_reset_recovery();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_data_mock.md
# cam_data_mock

Behavioural-RTL source emulating an OV7670 parallel camera port in RGB565 mode, used upstream of the camera capture/AXI-Stream block in simulation and on-board loopback tests. It divides the system clock into a pixel clock and emits VSYNC/HREF framing. Each pixel is sent as two data bytes with a deterministic, checkable pattern. After a fixed number of frames it stops and raises a sticky done flag.

## Interface
- PCLK_FREQ_MHZ, 24: nominal pixel-clock rate; documentation only, no behavioural effect.
- FRAME_WIDTH, 640: pixels per line (1..64 supported by the pattern; larger widths wrap the column field).
- FRAME_HEIGHT, 480: lines per frame (1..64 supported by the pattern; larger heights wrap the row field).
- FRAMES_TO_SEND, 10: number of frames emitted before stopping (≥1).

Ports:
- xclk  in  1: sole clock; all logic runs on its rising edge.
- reset  in  1: synchronous, active-high reset.
- enable  in  1: permission to start a frame.
- pclk  out  1: pixel clock, xclk/2.
- vsync  out  1: frame sync, active high.
- href  out  1: line valid, active high.
- data_out  out  8: pixel byte.
- frame_done  out  1: sticky; high once FRAMES_TO_SEND frames are complete.
- current_frame  out  2: completed-frame count mod 4.

## Operation
- The pattern word for frame f, row r and column c is P = {f[3:0], r[5:0], c[5:0]}. The byte order is P[15:8] first, then P[7:0].
- data_out is 0 whenever href is low.
- State machine (all counts in pclk periods):
  - IDLE: if enable=1 and frame_done=0, go to VSYNC.
  - VSYNC: vsync=1 for 4 periods, then VBACK.
  - VBACK: 8 periods, then LINE with row=0.
  - LINE: href=1 for 2·FRAME_WIDTH periods, bytes as above, col incremented after every second byte. Exit to HBLANK, or to VFRONT after row FRAME_HEIGHT-1.
  - HBLANK: 8 periods, row+1, then LINE.
  - VFRONT: 8 periods. Then the frame counter is incremented.
    - If the count equals FRAMES_TO_SEND, go to DONE.
    - Otherwise, if enable=1 go to VSYNC, else go to IDLE.
  - DONE: frame_done=1, all framing outputs low. Only reset leaves this state.
- enable is sampled only in IDLE and at the end of VFRONT. Dropping it mid-frame has no effect until the frame boundary.
- current_frame equals the low 2 bits of the completed-frame counter. The internal counter width is ≥ clog2(FRAMES_TO_SEND+1).
- Frame length is 12 + 2·W·H + 8·(H−1) + 8 pclk periods. For W=8, H=4 this is 108 periods, i.e. 216 xclk cycles.

## Timing
- pclk is a register that toggles every xclk cycle.
- vsync, href, data_out, state and counters update only on the xclk edge where pclk goes 1→0 (pclk falling edge).
- Those outputs are therefore stable across the following pclk rising edge, which is where a consumer samples them.
- Reset values: pclk=0, vsync=0, href=0, data_out=0, frame_done=0, current_frame=0, state=IDLE, all counters 0.
- Reset asserted at any point, including mid-line or in DONE, returns every output and counter to its reset value on the next xclk edge.
- With enable held high at reset release, vsync rises within 2 xclk cycles.
- frame_done and the final current_frame update occur in the same xclk cycle as the exit from VFRONT of the last frame.

## Structure
- Package cam_mock_pkg holds:
  - the state enum (IDLE, VSYNC, VBACK, LINE, HBLANK, VFRONT, DONE);
  - constants VSYNC_PCLKS=4, VBACK_PCLKS=8, HBLANK_PCLKS=8, VFRONT_PCLKS=8;
  - the pattern function pix_word(f, r, c).
- One sub-module, cam_mock_pclk_gen, provides the divide-by-2 pclk register and a single-cycle fall-edge strobe. All other logic lives in the top module.

## Test plan
- Hold reset, then release with enable=1 and W=8, H=4. Required: all outputs 0 during reset; vsync high for exactly 4 pclk periods; first href rises 8 pclk periods after vsync falls.
- Frame 0, row 1, col 2: bytes must be 0x00 then 0x42. Frame 1, row 3, col 7: bytes must be 0x10 then 0xC7.
- Count per frame: exactly 4 href pulses, each 16 pclk periods long, with 8-period gaps between lines; frame length is 216 xclk cycles.
- FRAMES_TO_SEND=10: exactly 10 vsync pulses. Then frame_done=1 and current_frame=2 (10 mod 4), with no further vsync or href activity.
- Drop enable mid-frame 2: frame 2 completes fully, then the block stays in IDLE. Re-raising enable starts frame 3 with f=3 in the pattern.
- Assert reset mid-line and after frame_done: all outputs return to 0 on the next edge, and the sequence restarts from frame 0.
